// File: rtl/sat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_pkg                                                              |
// | Shared literal/clause geometry and arbiter state encoding.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sat_pkg;
   localparam int LIT_WIDTH  = 11;
   localparam int CLA_LENGTH = 3;
   localparam int CLA_WIDTH  = CLA_LENGTH * LIT_WIDTH;

   typedef logic signed [LIT_WIDTH-1:0] lit_t;
   typedef logic [CLA_WIDTH-1:0]        cla_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      DRAIN = 3'd2,
      DONE  = 3'd3,
      ABORT = 3'd4
   } carb_state_e;

   // A clause whose every literal slot is 0 carries no information.
   function automatic logic cla_is_blank(input cla_t c);
      return (c == '0);
   endfunction
endpackage
`default_nettype wire

// File: rtl/cla_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cla_fifo                                                             |
// | Circular clause buffer with wrap-bit pointers, push/pop/flush.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cla_fifo
   import sat_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [CLA_WIDTH-1:0] wdata,
   input  logic                 pop,
   input  logic                 flush,
   output logic [CLA_WIDTH-1:0] rdata,
   output logic                 full,
   output logic                 empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] head_q, head_d;
   logic [AW:0] tail_q, tail_d;
   cla_t        mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign full  = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
   assign empty = (head_q == tail_q);
   assign rdata = mem_q[head_q[AW-1:0]];

   // Pointer update; a flush discards everything including a same-cycle push.
   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         if (do_push) tail_d = tail_q + (AW+1)'(1);
         if (do_pop)  head_d = head_q + (AW+1)'(1);
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[tail_q[AW-1:0]] <= wdata;
   end
endmodule
`default_nettype wire

// File: rtl/carb_dist_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | carb_dist_multi                                                      |
// | Clause arbiter/distributor: buffers a clause batch, broadcasts the   |
// | initial unit clause, round-robin dispatch, abort on conflict.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module carb_dist_multi
   import sat_pkg::*;
#(
   parameter int NUM_ENG   = 4,
   parameter int DEPTH     = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_start,
   input  logic                 mem_finish,
   input  logic [CLA_WIDTH-1:0] mem_clause,
   output logic                 mem_ready,
   input  logic                 uc_valid,
   input  logic [LIT_WIDTH-1:0] uc,
   output logic [NUM_ENG-1:0]   eng_cla_valid,
   output logic [CLA_WIDTH-1:0] eng_cla,
   input  logic [NUM_ENG-1:0]   eng_cla_ready,
   output logic                 eng_uc_valid,
   output logic [LIT_WIDTH-1:0] eng_uc,
   input  logic [NUM_ENG-1:0]   eng_conflict,
   output logic                 carb_empty,
   output logic                 done,
   output logic                 conflict,
   output logic [CNT_WIDTH-1:0] disp_cnt
);
   localparam int RRW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

   carb_state_e          state_q, state_d;
   logic                 uc_pend_q, uc_pend_d;
   logic [LIT_WIDTH-1:0] uc_q, uc_d;
   logic [RRW-1:0]       rr_q, rr_d;
   logic [NUM_ENG-1:0]   eng_cla_valid_q, eng_cla_valid_d;
   logic [CLA_WIDTH-1:0] eng_cla_q, eng_cla_d;
   logic [CNT_WIDTH-1:0] disp_cnt_q, disp_cnt_d;
   logic                 conflict_q, conflict_d;

   logic                 fifo_full, fifo_empty;
   logic [CLA_WIDTH-1:0] fifo_rdata;
   logic                 push, pop, flush;
   logic                 conflict_any, accept, leave_abort, uc_bcast, disp_ok;
   logic                 found;
   logic [RRW-1:0]       win;

   cla_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (mem_clause),
      .pop   (pop),
      .flush (flush),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Round-robin search: first ready engine at or after rr, modulo NUM_ENG.
   always_comb begin
      int             idx;
      logic [RRW-1:0] cand;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      cand  = '0;
      for (int k = 0; k < NUM_ENG; k++) begin
         idx  = (int'(rr_q) + k) % NUM_ENG;
         cand = idx[RRW-1:0];
         if (!found && eng_cla_ready[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Control: write acceptance, UC broadcast, dispatch decision and FSM.
   always_comb begin
      mem_ready    = !fifo_full && (state_q == IDLE || state_q == FILL);
      conflict_any = |eng_conflict;
      accept       = mem_start && mem_ready;
      leave_abort  = (state_q == ABORT) && mem_start && !conflict_any;
      push         = (accept || leave_abort) && !cla_is_blank(mem_clause);
      uc_bcast     = uc_pend_q && (state_q != ABORT);
      // UC must reach every engine before any clause does.
      disp_ok      = (state_q == FILL || state_q == DRAIN) && !fifo_empty && !uc_pend_q &&
                     !uc_valid && !conflict_any && found;
      pop          = disp_ok;
      flush        = conflict_any;

      state_d         = state_q;
      rr_d            = rr_q;
      eng_cla_valid_d = '0;
      eng_cla_d       = eng_cla_q;
      disp_cnt_d      = disp_cnt_q;
      conflict_d      = conflict_q;
      uc_d            = uc_valid ? uc : uc_q;
      uc_pend_d       = uc_valid ? 1'b1 : (uc_bcast ? 1'b0 : uc_pend_q);

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = mem_finish ? DRAIN : FILL;
               disp_cnt_d = '0;
            end
         end
         FILL:    if (accept && mem_finish) state_d = DRAIN;
         DRAIN:   if (fifo_empty && !uc_pend_q) state_d = DONE;
         DONE:    state_d = IDLE;
         ABORT: begin
            if (leave_abort) begin
               state_d    = IDLE;
               conflict_d = 1'b0;
               disp_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (disp_ok) begin
         eng_cla_valid_d[win] = 1'b1;
         eng_cla_d            = fifo_rdata;
         rr_d                 = (win == RRW'(NUM_ENG - 1)) ? '0 : win + RRW'(1);
         if (disp_cnt_q != '1) disp_cnt_d = disp_cnt_q + CNT_WIDTH'(1);
      end

      // A conflict overrides every other transition and cancels the pop.
      if (conflict_any) begin
         state_d    = ABORT;
         conflict_d = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         uc_pend_q       <= 1'b0;
         uc_q            <= '0;
         rr_q            <= '0;
         eng_cla_valid_q <= '0;
         eng_cla_q       <= '0;
         disp_cnt_q      <= '0;
         conflict_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         uc_pend_q       <= uc_pend_d;
         uc_q            <= uc_d;
         rr_q            <= rr_d;
         eng_cla_valid_q <= eng_cla_valid_d;
         eng_cla_q       <= eng_cla_d;
         disp_cnt_q      <= disp_cnt_d;
         conflict_q      <= conflict_d;
      end
   end

   assign eng_cla_valid = eng_cla_valid_q;
   assign eng_cla       = eng_cla_q;
   assign eng_uc_valid  = uc_bcast;
   assign eng_uc        = uc_q;
   assign carb_empty    = fifo_empty;
   assign done          = (state_q == DONE);
   assign conflict      = conflict_q;
   assign disp_cnt      = disp_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_carb_dist_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_carb_dist_multi                                                   |
// | Directed self-checking bench for carb_dist_multi.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_carb_dist_multi;
   import sat_pkg::*;

   localparam int NUM_ENG   = 4;
   localparam int DEPTH     = 16;
   localparam int CNT_WIDTH = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 mem_start, mem_finish;
   logic [CLA_WIDTH-1:0] mem_clause;
   logic                 mem_ready;
   logic                 uc_valid;
   logic [LIT_WIDTH-1:0] uc;
   logic [NUM_ENG-1:0]   eng_cla_valid;
   logic [CLA_WIDTH-1:0] eng_cla;
   logic [NUM_ENG-1:0]   eng_cla_ready;
   logic                 eng_uc_valid;
   logic [LIT_WIDTH-1:0] eng_uc;
   logic [NUM_ENG-1:0]   eng_conflict;
   logic                 carb_empty, done, conflict;
   logic [CNT_WIDTH-1:0] disp_cnt;

   int checks   = 0;
   int failures = 0;

   int                   cyc = 0;
   int                   got_eng[$];
   logic [CLA_WIDTH-1:0] got_cla[$];
   int                   uc_cyc, first_cyc, done_seen, bad_onehot;
   logic [LIT_WIDTH-1:0] uc_val;

   carb_dist_multi #(.NUM_ENG(NUM_ENG), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .mem_start(mem_start), .mem_finish(mem_finish),
      .mem_clause(mem_clause), .mem_ready(mem_ready), .uc_valid(uc_valid), .uc(uc),
      .eng_cla_valid(eng_cla_valid), .eng_cla(eng_cla), .eng_cla_ready(eng_cla_ready),
      .eng_uc_valid(eng_uc_valid), .eng_uc(eng_uc), .eng_conflict(eng_conflict),
      .carb_empty(carb_empty), .done(done), .conflict(conflict), .disp_cnt(disp_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [CLA_WIDTH-1:0] mk(input int a, input int b, input int c);
      return {LIT_WIDTH'(c), LIT_WIDTH'(b), LIT_WIDTH'(a)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_cap();
      got_eng.delete();
      got_cla.delete();
      uc_cyc = -1; first_cyc = -1; done_seen = 0; bad_onehot = 0; uc_val = '0;
   endtask

   // Advance one clock and record every strobe seen after the edge.
   task automatic tick_cap();
      @(posedge clk);
      #1;
      cyc++;
      if (eng_uc_valid) begin
         uc_cyc = cyc;
         uc_val = eng_uc;
      end
      if (done) done_seen++;
      if (eng_cla_valid != '0) begin
         if ($countones(eng_cla_valid) != 1) bad_onehot++;
         if (first_cyc < 0) first_cyc = cyc;
         for (int i = 0; i < NUM_ENG; i++) begin
            if (eng_cla_valid[i]) begin
               got_eng.push_back(i);
               got_cla.push_back(eng_cla);
            end
         end
      end
   endtask

   task automatic put(input logic [CLA_WIDTH-1:0] c, input logic fin);
      mem_start  = 1'b1;
      mem_finish = fin;
      mem_clause = c;
      tick_cap();
      mem_start  = 1'b0;
      mem_finish = 1'b0;
   endtask

   function automatic int q_eng(input int k);
      return (k < got_eng.size()) ? got_eng[k] : -1;
   endfunction

   function automatic logic [CLA_WIDTH-1:0] q_cla(input int k);
      return (k < got_cla.size()) ? got_cla[k] : '1;
   endfunction

   // Wait for the done pulse, then confirm it lasted exactly one cycle.
   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && done_seen == 0; i++) tick_cap();
      tick_cap();
      tick_cap();
      check({tag, "_done_once"}, done_seen, 1);
   endtask

   task automatic check_rst(input string tag);
      check({tag, "_mem_ready"}, mem_ready, 1);
      check({tag, "_carb_empty"}, carb_empty, 1);
      check({tag, "_eng_cla_valid"}, eng_cla_valid, 0);
      check({tag, "_eng_cla"}, eng_cla, 0);
      check({tag, "_eng_uc_valid"}, eng_uc_valid, 0);
      check({tag, "_eng_uc"}, eng_uc, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_conflict"}, conflict, 0);
      check({tag, "_disp_cnt"}, disp_cnt, 0);
   endtask

   initial begin
      logic [CLA_WIDTH-1:0] e1 [4];
      logic [CLA_WIDTH-1:0] e2 [4];
      rst_n = 1'b0; mem_start = 1'b0; mem_finish = 1'b0; mem_clause = '0;
      uc_valid = 1'b0; uc = '0; eng_cla_ready = '0; eng_conflict = '0;
      clr_cap();

      // Reset state
      tick_cap();
      tick_cap();
      check_rst("reset");
      rst_n = 1'b1;
      tick_cap();

      // 1: normal batch, UC broadcast first, engines 0..3 in order
      e1[0] = mk(1, 2, 7); e1[1] = mk(2, -1, 5); e1[2] = mk(0, 3, 1); e1[3] = mk(6, 3, 1);
      clr_cap();
      eng_cla_ready = 4'b1111;
      uc_valid = 1'b1; uc = 11'h7FF;
      put(e1[0], 1'b0);
      uc_valid = 1'b0;
      put(e1[1], 1'b0);
      put(e1[2], 1'b0);
      put(e1[3], 1'b1);
      wait_done("t1", 30);
      check("t1_uc_seen_before_cla", (uc_cyc >= 0) && (first_cyc > uc_cyc), 1);
      check("t1_uc_value", uc_val, 11'h7FF);
      check("t1_count", got_eng.size(), 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t1_eng%0d", k), q_eng(k), k);
         check($sformatf("t1_cla%0d", k), q_cla(k), e1[k]);
      end
      check("t1_onehot", bad_onehot, 0);
      check("t1_disp_cnt", disp_cnt, 4);
      check("t1_empty", carb_empty, 1);

      // 2: round-robin skip over unready engines
      clr_cap();
      eng_cla_ready = 4'b0101;
      for (int k = 0; k < 4; k++) e2[k] = mk(k + 1, -(k + 1), 9);
      for (int k = 0; k < 4; k++) put(e2[k], k == 3);
      wait_done("t2", 30);
      check("t2_count", got_eng.size(), 4);
      check("t2_eng0", q_eng(0), 0);
      check("t2_eng1", q_eng(1), 2);
      check("t2_eng2", q_eng(2), 0);
      check("t2_eng3", q_eng(3), 2);
      check("t2_cla3", q_cla(3), e2[3]);
      check("t2_disp_cnt", disp_cnt, 4);

      // 3: fill to full with no engine ready, 17th write is lost
      clr_cap();
      eng_cla_ready = 4'b0000;
      for (int k = 0; k < 15; k++) put(mk(k + 1, 4, 0), 1'b0);
      check("t3_ready_after15", mem_ready, 1);
      put(mk(16, 4, 0), 1'b0);
      check("t3_ready_after16", mem_ready, 0);
      put(mk(99, 99, 99), 1'b0);
      check("t3_none_dispatched", got_eng.size(), 0);
      eng_cla_ready = 4'b1111;
      for (int i = 0; i < 40 && got_eng.size() < 16; i++) tick_cap();
      tick_cap();
      tick_cap();
      check("t3_count", got_eng.size(), 16);
      check("t3_first_eng_rr", q_eng(0), 3);
      for (int k = 0; k < 16; k++) check($sformatf("t3_cla%0d", k), q_cla(k), mk(k + 1, 4, 0));
      check("t3_empty", carb_empty, 1);
      check("t3_ready_again", mem_ready, 1);
      check("t3_disp_cnt", disp_cnt, 16);
      put(mk(0, 0, 0), 1'b1);
      wait_done("t3", 10);

      // 4: conflict in DRAIN with 3 clauses queued
      clr_cap();
      eng_cla_ready = 4'b0000;
      put(mk(1, 1, 2), 1'b0);
      put(mk(1, 1, 3), 1'b0);
      put(mk(1, 1, 4), 1'b1);
      check("t4_queued", carb_empty, 0);
      eng_cla_ready = 4'b1111;
      eng_conflict = 4'b0010;
      tick_cap();
      eng_conflict = 4'b0000;
      check("t4_conflict", conflict, 1);
      check("t4_flushed", carb_empty, 1);
      check("t4_ready_low", mem_ready, 0);
      for (int i = 0; i < 4; i++) tick_cap();
      check("t4_no_strobe", got_eng.size(), 0);
      check("t4_conflict_held", conflict, 1);
      put(mk(5, 6, 7), 1'b0);
      check("t4_conflict_cleared", conflict, 0);
      check("t4_restart_stored", carb_empty, 0);
      check("t4_restart_ready", mem_ready, 1);
      put(mk(8, 9, 10), 1'b1);
      wait_done("t4", 20);
      check("t4_count", got_eng.size(), 2);
      check("t4_eng0", q_eng(0), 3);
      check("t4_cla0", q_cla(0), mk(5, 6, 7));
      check("t4_eng1", q_eng(1), 0);
      check("t4_cla1", q_cla(1), mk(8, 9, 10));
      check("t4_disp_cnt", disp_cnt, 2);

      // 5: all-zero clause is dropped
      clr_cap();
      put(mk(1, 1, 1), 1'b0);
      put(mk(0, 0, 0), 1'b0);
      put(mk(2, 2, 2), 1'b1);
      wait_done("t5", 20);
      check("t5_count", got_eng.size(), 2);
      check("t5_cla0", q_cla(0), mk(1, 1, 1));
      check("t5_cla1", q_cla(1), mk(2, 2, 2));
      check("t5_eng0", q_eng(0), 1);
      check("t5_disp_cnt", disp_cnt, 2);

      // 6: reset mid-FILL with 5 stored
      clr_cap();
      eng_cla_ready = 4'b0000;
      uc_valid = 1'b1; uc = 11'h00C;
      put(mk(3, 1, 1), 1'b0);
      uc_valid = 1'b0;
      for (int k = 0; k < 4; k++) put(mk(3, 2, k + 1), 1'b0);
      tick_cap();
      check("t6_stored", carb_empty, 0);
      check("t6_uc_seen", uc_val, 11'h00C);
      rst_n = 1'b0;
      tick_cap();
      check_rst("t6_rst");
      rst_n = 1'b1;
      clr_cap();
      eng_cla_ready = 4'b1111;
      put(mk(3, 3, 3), 1'b1);
      wait_done("t6", 20);
      check("t6_count", got_eng.size(), 1);
      check("t6_eng_rr_reset", q_eng(0), 0);
      check("t6_cla", q_cla(0), mk(3, 3, 3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
